// File: rtl/seq_grant_pkg.sv
// Shared types and helpers for the multi-channel service sequencer.
// State encodings are fixed so that the unused code 3'd7 is the only illegal value.
package seq_grant_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        SCAN  = 3'd2,
        GRANT = 3'd3,
        WAIT  = 3'd4,
        TMO   = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic MODE_PRIO = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    function automatic int clog2_min1(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/grant_pick.sv
// Combinational channel picker: lowest eligible index, or the first eligible
// index after the last granted one (wrapping) in round-robin mode.
module grant_pick
    import seq_grant_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] elig,
    input  logic           mode_q,
    input  logic [CW-1:0]  last,
    output logic [CW-1:0]  pick,
    output logic           any
);

    always_comb begin
        int            first;
        int            idx;
        logic [CW-1:0] idx_c;
        logic          found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        idx_c = '0;
        first = (mode_q == MODE_RR) ? ((int'(last) + 1) % NCH) : 0;
        for (int k = 0; k < NCH; k++) begin
            idx   = (first + k) % NCH;
            idx_c = CW'(idx);
            if (!found && elig[idx_c]) begin
                pick  = idx_c;
                found = 1'b1;
            end
        end
        any = |elig;
    end

endmodule

// File: rtl/seq_grant_fsm.sv
// Service sequencer: arms on start, grants requesting channels until done or
// timeout, masks timed-out channels and finishes after a service budget.
module seq_grant_fsm
    import seq_grant_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int TMO_MAX = 8,
    parameter int MAX_SVC = 6,
    parameter int CW      = $clog2(NCH),
    parameter int SW      = $clog2(MAX_SVC + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic           abort,
    input  logic [NCH-1:0] req,
    input  logic           done,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  ch_id,
    output logic           busy,
    output logic           arm,
    output logic           tmo_err,
    output logic           fin,
    output logic [NCH-1:0] mask,
    output logic [SW-1:0]  svc_cnt
);

    localparam int TW = clog2_min1(TMO_MAX);

    state_t         state_q, state_n;
    logic [CW-1:0]  ch_q, ch_n;
    logic [CW-1:0]  last_q, last_n;
    logic           mode_q, mode_n;
    logic [NCH-1:0] mask_q, mask_n;
    logic [SW-1:0]  svc_q, svc_n, svc_inc;
    logic [TW-1:0]  timer_q, timer_n;
    logic [CW-1:0]  pick;
    logic           any;
    logic           legal;

    grant_pick #(.NCH(NCH), .CW(CW)) u_pick (
        .elig   (req & ~mask_q),
        .mode_q (mode_q),
        .last   (last_q),
        .pick   (pick),
        .any    (any)
    );

    assign svc_inc = svc_q + SW'(1);

    always_comb begin
        state_n = state_q;
        ch_n    = ch_q;
        last_n  = last_q;
        mode_n  = mode_q;
        mask_n  = mask_q;
        svc_n   = svc_q;
        timer_n = timer_q;
        legal   = 1'b1;
        gnt     = '0;
        busy    = 1'b1;
        arm     = 1'b0;
        tmo_err = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = ARM;
            end
            ARM: begin
                arm     = 1'b1;
                mode_n  = mode;
                mask_n  = '0;
                svc_n   = '0;
                timer_n = '0;
                last_n  = CW'(NCH - 1);
                state_n = SCAN;
            end
            SCAN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (any) begin
                    ch_n    = pick;
                    state_n = GRANT;
                end else if (&mask_q) begin
                    state_n = FIN;
                end
            end
            GRANT: begin
                gnt     = NCH'(1) << ch_q;
                last_n  = ch_q;
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                gnt = NCH'(1) << ch_q;
                if (abort) begin
                    state_n = IDLE;
                end else if (done) begin
                    svc_n   = svc_inc;
                    state_n = (svc_inc == SW'(MAX_SVC)) ? FIN : SCAN;
                end else if (timer_q == TW'(TMO_MAX - 1)) begin
                    state_n = TMO;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            TMO: begin
                tmo_err       = 1'b1;
                mask_n[ch_q]  = 1'b1;
                state_n       = SCAN;
            end
            FIN: begin
                fin     = 1'b1;
                state_n = IDLE;
            end
            default: begin
                // Corrupted state code: blank every output and recover to IDLE.
                legal   = 1'b0;
                busy    = 1'b0;
                state_n = IDLE;
                mask_n  = '0;
                svc_n   = '0;
                timer_n = '0;
            end
        endcase
        ch_id   = legal ? ch_q   : '0;
        mask    = legal ? mask_q : '0;
        svc_cnt = legal ? svc_q  : '0;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            last_q  <= CW'(NCH - 1);
            mode_q  <= MODE_PRIO;
            mask_q  <= '0;
            svc_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_n;
            ch_q    <= ch_n;
            last_q  <= last_n;
            mode_q  <= mode_n;
            mask_q  <= mask_n;
            svc_q   <= svc_n;
            timer_q <= timer_n;
        end
    end

endmodule

// File: tb/tb_seq_grant_fsm.sv
// Randomized session-level bench for seq_grant_fsm with a queued scoreboard.
// The stimulus process walks each session procedurally and queues the expected outputs.
module tb_seq_grant_fsm;

    localparam int NCH     = 4;
    localparam int TMO_MAX = 3;
    localparam int MAX_SVC = 4;
    localparam int CW      = 2;
    localparam int SW      = 3;

    typedef struct packed {
        logic [NCH-1:0] gnt;
        logic [CW-1:0]  ch;
        logic           busy;
        logic           arm;
        logic           tmo;
        logic           fin;
        logic [NCH-1:0] mask;
        logic [SW-1:0]  svc;
    } obs_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic           abort = 1'b0;
    logic [NCH-1:0] req = '0;
    logic           done = 1'b0;
    logic [NCH-1:0] gnt;
    logic [CW-1:0]  ch_id;
    logic           busy;
    logic           arm;
    logic           tmo_err;
    logic           fin;
    logic [NCH-1:0] mask;
    logic [SW-1:0]  svc_cnt;

    seq_grant_fsm #(.NCH(NCH), .TMO_MAX(TMO_MAX), .MAX_SVC(MAX_SVC)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .req(req), .done(done), .gnt(gnt), .ch_id(ch_id), .busy(busy),
        .arm(arm), .tmo_err(tmo_err), .fin(fin), .mask(mask), .svc_cnt(svc_cnt)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    // Reference model: what the sequencer should currently be holding.
    logic [CW-1:0]  m_ch = '0;
    logic [CW-1:0]  m_last = CW'(NCH - 1);
    logic           m_mode = 1'b0;
    logic [NCH-1:0] m_mask = '0;
    logic [SW-1:0]  m_svc = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, req_v, $time);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [NCH-1:0] rr();
        return NCH'($urandom_range(0, (1 << NCH) - 1));
    endfunction

    function automatic obs_t mk(input bit g, input bit b, input bit ar, input bit tm, input bit fi);
        obs_t o;
        o.gnt  = g ? (NCH'(1) << m_ch) : '0;
        o.ch   = m_ch;
        o.busy = b;
        o.arm  = ar;
        o.tmo  = tm;
        o.fin  = fi;
        o.mask = m_mask;
        o.svc  = m_svc;
        return o;
    endfunction

    // Round-robin: first eligible channel above the last one, else the lowest eligible.
    function automatic logic [CW-1:0] ref_pick(input logic [NCH-1:0] el);
        if (m_mode) begin
            for (int i = int'(m_last) + 1; i < NCH; i++)
                if (el[i]) return CW'(i);
        end
        for (int i = 0; i < NCH; i++)
            if (el[i]) return CW'(i);
        return '0;
    endfunction

    task automatic step(input logic s, input logic md, input logic ab, input logic dn,
                        input logic [NCH-1:0] rq, input obs_t e);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = s;
        mode  = md;
        abort = ab;
        done  = dn;
        req   = rq;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_svc", 32'(svc_cnt), 32'd0);
        m_ch   = '0;
        m_mask = '0;
        m_svc  = '0;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
    endtask

    task automatic session(input int done_pct, input bit do_rst);
        logic [NCH-1:0] r, el;
        logic           a, d, mm;
        int             stays;
        repeat ($urandom_range(0, 2)) step(1'b0, rb(), rb(), rb(), rr(), mk(0, 0, 0, 0, 0));
        step(1'b1, rb(), rb(), rb(), rr(), mk(0, 1, 1, 0, 0));
        mm     = rb();
        m_mode = mm;
        m_mask = '0;
        m_svc  = '0;
        m_last = CW'(NCH - 1);
        step(rb(), mm, rb(), rb(), rr(), mk(0, 1, 0, 0, 0));
        stays = 0;
        forever begin
            r  = rr();
            a  = ($urandom_range(0, 39) == 0) || (stays > 20);
            el = r & ~m_mask;
            if (a) begin
                step(rb(), rb(), 1'b1, rb(), r, mk(0, 0, 0, 0, 0));
                return;
            end
            if (el != '0) begin
                m_ch = ref_pick(el);
                step(rb(), rb(), 1'b0, rb(), r, mk(1, 1, 0, 0, 0));
                m_last = m_ch;
                step(rb(), rb(), rb(), rb(), rr(), mk(1, 1, 0, 0, 0));
                for (int t = 0; t < TMO_MAX; t++) begin
                    if (do_rst && t == 1) begin
                        do_reset();
                        return;
                    end
                    a = ($urandom_range(0, 29) == 0);
                    d = ($urandom_range(0, 99) < done_pct);
                    if (a) begin
                        step(rb(), rb(), 1'b1, d, rr(), mk(0, 0, 0, 0, 0));
                        return;
                    end
                    if (d) begin
                        m_svc = m_svc + 1'b1;
                        if (int'(m_svc) == MAX_SVC) begin
                            step(rb(), rb(), 1'b0, 1'b1, rr(), mk(0, 1, 0, 0, 1));
                            step(1'b0, rb(), rb(), rb(), rr(), mk(0, 0, 0, 0, 0));
                            return;
                        end
                        step(rb(), rb(), 1'b0, 1'b1, rr(), mk(0, 1, 0, 0, 0));
                        break;
                    end
                    if (t == TMO_MAX - 1) begin
                        step(rb(), rb(), 1'b0, 1'b0, rr(), mk(0, 1, 0, 1, 0));
                        m_mask[m_ch] = 1'b1;
                        step(rb(), rb(), rb(), rb(), rr(), mk(0, 1, 0, 0, 0));
                    end else begin
                        step(rb(), rb(), 1'b0, 1'b0, rr(), mk(1, 1, 0, 0, 0));
                    end
                end
                stays = 0;
            end else if (&m_mask) begin
                step(rb(), rb(), 1'b0, rb(), r, mk(0, 1, 0, 0, 1));
                step(1'b0, rb(), rb(), rb(), rr(), mk(0, 0, 0, 0, 0));
                return;
            end else begin
                step(rb(), rb(), 1'b0, rb(), r, mk(0, 1, 0, 0, 0));
                stays++;
            end
        end
    endtask

    // Monitor: one expected record per sampled cycle, taken on the rising edge.
    initial begin
        obs_t act, e;
        forever begin
            @(posedge clk);
            if (mon_en) begin
                act = {gnt, ch_id, busy, arm, tmo_err, fin, mask, svc_cnt};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL outputs: got %h with nothing expected at %0t", act, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("outputs", 32'(act), 32'(e));
                end
            end
        end
    end

    initial begin
        #1;
        rst = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        mon_en = 1'b1;
        for (int i = 0; i < 90; i++) begin
            case (i % 5)
                3:       session(100, i % 7 == 6);
                4:       session(0, i % 7 == 6);
                default: session(45, i % 7 == 6);
            endcase
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
